rt_scene_fetch_ctrl: RTL
========================

Name: rt_scene_fetch_ctrl

Overview:
Sequencer that sits between the ray tracer's 16-bit Avalon-MM read master and the ray/triangle intersector datapath. On start it fetches the ray descriptor, then the triangle count, then streams triangles one at a time to the intersector under a valid/ready handshake. It assembles 16-bit bus halfwords into 32-bit Q16.16 words and reports completion. It is the fetch/control half of the top-level ray_tracer.

Parameters:
ADDR_W, 32, Avalon byte-address width
CNT_W, 16, width of triangle count and index
MAX_TRIS, 16'hFFFF, counts above this set o_err and finish without streaming

Ports:
clk  in  1  clock
reset  in  1  synchronous active-low reset (reset=0 resets)
start_rt  in  1  one-cycle start pulse
i_baseaddr  in  ADDR_W  scene base byte address, sampled on accepted start
end_rt  out  1  one-cycle done pulse
o_busy  out  1  high from accepted start until end_rt
o_err  out  1  sticky count-overflow flag, cleared on next accepted start
avm_m0_read  out  1  Avalon read request
avm_m0_address  out  ADDR_W  Avalon byte address
avm_m0_byteenable  out  2  constant 2'b11
avm_m0_readdata  in  16  read data
avm_m0_readdatavalid  in  1  read data valid
avm_m0_waitrequest  in  1  slave stall
o_ray  out  192  {dir z,y,x, orig z,y,x}, word 0 in [31:0]
o_ray_valid  out  1  level, high once ray fully loaded, until done/start
o_tri_cnt  out  CNT_W  latched triangle count
o_tri  out  288  9 words {v2 zyx, v1 zyx, v0 zyx}, word 0 in [31:0]
o_tri_valid  out  1  triangle presented
i_tri_ready  in  1  intersector accepts triangle
o_tri_index  out  CNT_W  index of presented triangle
o_tri_last  out  1  presented triangle is index cnt-1

Behaviour:
- Memory layout (byte offsets from base): ray 0..23 (6 words), count 24..27 (low 16 bits used, upper halfword must read but is ignored), triangle i at 28+36*i. Each 32-bit word is low halfword at lower address, then high halfword.
- One outstanding read at most: assert avm_m0_read with address; hold read/address stable while waitrequest=1; drop read the cycle after acceptance (read=1 & waitrequest=0); wait for readdatavalid before next read. Address steps by 2 per halfword.
- readdatavalid when no read is outstanding is ignored.
- States: IDLE -> RAY (12 halfwords) -> CNT (2 halfwords) -> TRI_FETCH (18 halfwords) -> TRI_PRESENT -> TRI_FETCH ... -> DONE -> IDLE.
- IDLE: start_rt=1 latches base, clears o_err, o_ray_valid, index; o_busy=1 next cycle; first read issued the cycle after start. start_rt while busy is ignored.
- RAY end: o_ray_valid=1 in the cycle after the 12th halfword.
- CNT: count=0 -> DONE; count>MAX_TRIS -> o_err=1, DONE; else TRI_FETCH index 0.
- TRI_PRESENT: o_tri_valid=1 with o_tri, o_tri_index, o_tri_last stable until i_tri_ready=1; transfer on valid&ready; next fetch read issued the following cycle; after last triangle -> DONE. No read issued while presenting.
- DONE: end_rt=1 for exactly one cycle, o_busy=0 same cycle as end_rt, o_ray_valid=0, return to IDLE.
- Reset values: all outputs 0 except byteenable=2'b11; state IDLE. Reset mid-operation aborts immediately: read drops the next cycle, late readdatavalid is ignored, no end_rt.
- Latency with zero-wait slave, 2-cycle read latency (accept+1 cycle return): each halfword = 3 cycles.

Test Plan:
- Ray load: base 0x1000, ray {0,0,0x10000, 0,0,0xFFFF0000}, count 0 -> addresses 0x1000..0x101A by 2, o_ray word2=0x00010000, word5=0xFFFF0000, end_rt one cycle, o_err=0, no tri_valid.
- Three triangles (count 3, tri0 v0={0,0x20000,0xFFFE0000}), ready always 1 -> o_tri_index 0,1,2, o_tri_last only at 2, tri1 fetch starts at 0x1040, end_rt after third transfer.
- Backpressure: i_tri_ready low 10 cycles on tri 1 -> o_tri/index stable, avm_m0_read stays 0, no data loss.
- Waitrequest high 4 cycles on halfword 5 -> read and address held at 0x100A, halfword assembled correctly.
- Count 0x0010 with MAX_TRIS=8 -> o_err=1, end_rt, no triangles; next start clears o_err.
- Reset low during TRI_FETCH of tri 1, then stray readdatavalid -> IDLE, outputs zero, no end_rt; subsequent start runs full 3-triangle scene correctly.

Source files
------------

// File: rtl/rt_scene_fetch_ctrl_if.sv
// Bus bundle for the scene fetch sequencer: Avalon-MM read master plus the
// triangle stream towards the intersector.
interface rt_scene_fetch_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  logic              avm_m0_read;
  logic [ADDR_W-1:0] avm_m0_address;
  logic [1:0]        avm_m0_byteenable;
  logic [15:0]       avm_m0_readdata;
  logic              avm_m0_readdatavalid;
  logic              avm_m0_waitrequest;

  // Triangle stream: a transfer happens on a clock edge where o_tri_valid and
  // i_tri_ready are both 1; while valid is high and ready is low, o_tri,
  // o_tri_index and o_tri_last hold steady and valid does not drop.
  logic [287:0]      o_tri;
  logic              o_tri_valid;
  logic              i_tri_ready;
  logic [CNT_W-1:0]  o_tri_index;
  logic              o_tri_last;

  modport master (
    output avm_m0_read, avm_m0_address, avm_m0_byteenable,
    input  avm_m0_readdata, avm_m0_readdatavalid, avm_m0_waitrequest,
    output o_tri, o_tri_valid, o_tri_index, o_tri_last,
    input  i_tri_ready
  );

  modport slave (
    input  avm_m0_read, avm_m0_address, avm_m0_byteenable,
    output avm_m0_readdata, avm_m0_readdatavalid, avm_m0_waitrequest,
    input  o_tri, o_tri_valid, o_tri_index, o_tri_last,
    output i_tri_ready
  );
endinterface

// File: rtl/rt_scene_fetch_ctrl.sv
// Fetch/control half of the ray tracer: loads ray and triangle count over a
// 16-bit Avalon read master, then streams 32-bit-assembled triangles out.
module rt_scene_fetch_ctrl #(
  parameter int               ADDR_W   = 32,
  parameter int               CNT_W    = 16,
  parameter logic [CNT_W-1:0] MAX_TRIS = 16'hFFFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_rt,
  input  logic [ADDR_W-1:0]  i_baseaddr,
  output logic               end_rt,
  output logic               o_busy,
  output logic               o_err,
  output logic [191:0]       o_ray,
  output logic               o_ray_valid,
  output logic [CNT_W-1:0]   o_tri_cnt,
  output logic [2:0]         dbg_state,
  rt_scene_fetch_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_RAY, S_CNT, S_TRI_FETCH, S_TRI_PRESENT, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic              rd_req, rd_wait;
  logic [ADDR_W-1:0] addr_q;
  logic [4:0]        hw_idx;
  logic [191:0]      ray_q;
  logic              ray_valid_q;
  logic [287:0]      tri_q;
  logic [CNT_W-1:0]  cnt_q, tri_idx;
  logic              err_q;
  logic              start_acc, rd_accept, hw_done, tri_xfer, last_tri, cnt_over;
  logic              fetch_next;

  assign start_acc = (state == S_IDLE) && start_rt;
  assign rd_accept = rd_req && !bus.avm_m0_waitrequest;
  // Data only counts while a read is actually outstanding; strays are dropped.
  assign hw_done   = rd_wait && bus.avm_m0_readdatavalid;
  assign last_tri  = (tri_idx == cnt_q - CNT_W'(1));
  assign tri_xfer  = (state == S_TRI_PRESENT) && bus.i_tri_ready;
  assign cnt_over  = (cnt_q > MAX_TRIS);

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:        if (start_rt) state_nxt = S_RAY;
      S_RAY:         if (hw_done && hw_idx == 5'd11) state_nxt = S_CNT;
      S_CNT: begin
        if (hw_done && hw_idx == 5'd1) begin
          if (cnt_q == '0 || cnt_over) state_nxt = S_DONE;
          else                         state_nxt = S_TRI_FETCH;
        end
      end
      S_TRI_FETCH:   if (hw_done && hw_idx == 5'd17) state_nxt = S_TRI_PRESENT;
      S_TRI_PRESENT: if (bus.i_tri_ready) state_nxt = last_tri ? S_DONE : S_TRI_FETCH;
      S_DONE:        state_nxt = S_IDLE;
      default:       state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy          = (state inside {S_RAY, S_CNT, S_TRI_FETCH, S_TRI_PRESENT});
    end_rt          = (state == S_DONE);
    bus.o_tri_valid = (state == S_TRI_PRESENT);
    bus.o_tri_last  = (state == S_TRI_PRESENT) && last_tri;
  end

  // Next halfword request goes out on the same edge that retires the previous one.
  assign fetch_next = (state_nxt inside {S_RAY, S_CNT, S_TRI_FETCH}) &&
                      (start_acc || hw_done || tri_xfer);

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_req      <= 1'b0;
      rd_wait     <= 1'b0;
      addr_q      <= '0;
      hw_idx      <= '0;
      ray_q       <= '0;
      ray_valid_q <= 1'b0;
      tri_q       <= '0;
      cnt_q       <= '0;
      tri_idx     <= '0;
      err_q       <= 1'b0;
    end else begin
      if (start_acc) begin
        addr_q      <= i_baseaddr;
        err_q       <= 1'b0;
        ray_valid_q <= 1'b0;
        tri_idx     <= '0;
      end
      if (rd_accept) begin
        rd_req  <= 1'b0;
        rd_wait <= 1'b1;
        addr_q  <= addr_q + ADDR_W'(2);
      end
      if (hw_done)    rd_wait <= 1'b0;
      if (fetch_next) rd_req  <= 1'b1;

      if (state_nxt != state) hw_idx <= '0;
      else if (hw_done)       hw_idx <= hw_idx + 5'd1;

      if (hw_done) begin
        case (state)
          S_RAY:       ray_q[{hw_idx[3:0], 4'b0000} +: 16] <= bus.avm_m0_readdata;
          S_CNT:       if (hw_idx == 5'd0) cnt_q <= CNT_W'(bus.avm_m0_readdata);
          S_TRI_FETCH: tri_q[{hw_idx, 4'b0000} +: 16] <= bus.avm_m0_readdata;
          default:     ;
        endcase
      end

      if (state == S_RAY && state_nxt == S_CNT)             ray_valid_q <= 1'b1;
      if (state_nxt == S_DONE)                              ray_valid_q <= 1'b0;
      if (state == S_CNT && state_nxt == S_DONE && cnt_over) err_q      <= 1'b1;
      if (tri_xfer && !last_tri)                            tri_idx     <= tri_idx + CNT_W'(1);
    end
  end

  assign bus.avm_m0_read       = rd_req;
  assign bus.avm_m0_address    = addr_q;
  assign bus.avm_m0_byteenable = 2'b11;
  assign bus.o_tri             = tri_q;
  assign bus.o_tri_index       = tri_idx;
  assign o_ray                 = ray_q;
  assign o_ray_valid           = ray_valid_q;
  assign o_tri_cnt             = cnt_q;
  assign o_err                 = err_q;
  assign dbg_state             = state;

endmodule
